// File: rtl/itrx_aib_aux_rx_filt.sv
// itrx_aib_aux_rx_filt
//
// Core-side receiver for one AIB AUX sideband level coming down from the IO
// (vcc) domain. The input is already level-shifted; this block only synchronises
// it into clk, rejects pulses shorter than filt_len cycles, and forces aux_out to
// RST_VAL while the IO supply is not good.
//
// Ports:
//   clk         core clock, rising edge
//   rst_n       asynchronous active-low reset
//   aux_in      AUX level, asynchronous to clk
//   pwr_ok      IO supply good, asynchronous to clk
//   filt_len    filter length in clk cycles (0 behaves as 1), quasi-static
//   aux_out     filtered AUX level
//   aux_rise    one-cycle pulse on each accepted 0->1 of aux_out
//   aux_fall    one-cycle pulse on each accepted 1->0 of aux_out
//   aux_stable  high while tracking a qualified level
module itrx_aib_aux_rx_filt #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 8,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aux_in,
    input  logic              pwr_ok,
    input  logic [FILT_W-1:0] filt_len,
    output logic              aux_out,
    output logic              aux_rise,
    output logic              aux_fall,
    output logic              aux_stable
);

    typedef enum logic [1:0] {StGated, StAcquire, StTrack} state_e;

    logic [SYNC_STAGES-1:0] in_sync_q;
    logic [SYNC_STAGES-1:0] pok_sync_q;
    logic                   sync_in;
    logic                   pok_s;

    state_e            state_q, state_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic              cand_q, cand_d;
    logic              out_q, out_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              stable_q, stable_d;

    logic [FILT_W-1:0] len_eff;
    logic [FILT_W:0]   cnt_inc;
    logic              len_hit;
    logic [FILT_W-1:0] cnt_sat;

    // Synchronisers. Input chain resets to the safe level, pwr_ok chain to "not good".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_sync_q  <= {SYNC_STAGES{RST_VAL}};
            pok_sync_q <= '0;
        end else begin
            in_sync_q  <= {in_sync_q[SYNC_STAGES-2:0], aux_in};
            pok_sync_q <= {pok_sync_q[SYNC_STAGES-2:0], pwr_ok};
        end
    end

    assign sync_in = in_sync_q[SYNC_STAGES-1];
    assign pok_s   = pok_sync_q[SYNC_STAGES-1];

    // Compare against the live filt_len so a shrink takes effect on the next edge.
    assign len_eff = (filt_len == '0) ? FILT_W'(1) : filt_len;
    assign cnt_inc = {1'b0, cnt_q} + (FILT_W + 1)'(1);
    assign len_hit = (cnt_inc >= {1'b0, len_eff});
    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + FILT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (!pok_s) begin
            // Supply loss overrides everything; the forced change is silent.
            state_d = StGated;
            cnt_d   = '0;
            cand_d  = RST_VAL;
            out_d   = RST_VAL;
        end else begin
            unique case (state_q)
                StGated: begin
                    state_d = StAcquire;
                    cnt_d   = '0;
                    cand_d  = RST_VAL;
                    out_d   = RST_VAL;
                end
                StAcquire: begin
                    if (sync_in != cand_q) begin
                        cand_d = sync_in;
                        cnt_d  = FILT_W'(1);
                    end else if (len_hit) begin
                        // Initial load after power-up is not an edge event.
                        out_d   = cand_q;
                        cnt_d   = '0;
                        state_d = StTrack;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
                StTrack: begin
                    if (sync_in == out_q) begin
                        cnt_d = '0;
                    end else if (len_hit) begin
                        out_d  = sync_in;
                        cnt_d  = '0;
                        rise_d = sync_in;
                        fall_d = ~sync_in;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
                default: begin
                    state_d = StGated;
                    cnt_d   = '0;
                    cand_d  = RST_VAL;
                    out_d   = RST_VAL;
                end
            endcase
        end

        stable_d = (state_d == StTrack);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StGated;
            cnt_q    <= '0;
            cand_q   <= RST_VAL;
            out_q    <= RST_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            stable_q <= stable_d;
        end
    end

    assign aux_out    = out_q;
    assign aux_rise   = rise_q;
    assign aux_fall   = fall_q;
    assign aux_stable = stable_q;

endmodule
